// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// first-word-fallthrough FIFO with a valid/ready read port and sticky error flags.
`timescale 1ns/1ps

module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         rx,
    output logic [7:0]                   rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overrun,
    output logic                         frame_err,
    output logic                         parity_err,
    input  logic                         err_clr
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state, state_next;
    logic             rx_meta, rx_s;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_cnt, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             push_q, push_next;
    logic             frame_evt;
`ifdef UART_RX_PARITY_EN
    logic             par_bad, par_bad_next;
    logic             par_evt;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            state     <= state_next;
            cnt       <= cnt_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            push_q    <= push_next;
            if (frame_evt)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        push_next  = 1'b0;
        frame_evt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad;
        par_evt      = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s)
                    state_next = START;
            end
            START: begin
                if (cnt == HALF_CNT) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_CNT) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL_CNT) begin
                    cnt_next     = '0;
                    par_bad_next = ^{shift_reg, rx_s};
                    par_evt      = par_bad_next;
                    state_next   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL_CNT) begin
                    cnt_next = '0;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        push_next = !par_bad;
`else
                        push_next = 1'b1;
`endif
                        state_next = IDLE;
                    end else begin
                        frame_evt  = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low break line parks here, so it raises frame_err only once.
                cnt_next = '0;
                if (rx_s)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad <= par_bad_next;
            if (par_evt)
                parity_err <= 1'b1;
            else if (err_clr)
                parity_err <= 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, do_push, do_pop;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = rd_valid && rd_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_q && (!full || do_pop);

    // NOTE: the storage array is not reset; only pointers and count are, which is enough to mark it empty.
    always_ff @(posedge clk) begin
        if (reset_n && do_push)
            mem[wr_ptr] <= shift_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push_q && !do_push)
                overrun <= 1'b1;
            else if (err_clr)
                overrun <= 1'b0;
        end
    end

    assign rd_valid   = (count != '0);
    assign rd_data    = rd_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count = count;

endmodule
